lora_burst_gate: RTL and testbench

Parametrised successor to the LoRa packet detector. It computes a moving-average power over the incoming complex sample stream and uses on/off hysteresis thresholds plus a hang timer to gate whole bursts through to the output. A pre-trigger history buffer lets each burst start before the detection point, and every burst is framed with `TLAST`. It sits between the AXI wrapper's master stream and the downstream copy/trigger stages, in the compute-engine clock domain.

---
 rtl/lora_burst_gate.sv | 229 ++++++++++++++++++++++
 tb/tb_lora_burst_gate.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lora_burst_gate.sv
// rtl/lora_burst_gate.sv - moving-average power burst gate with pre-trigger history and TLAST framing
module lora_burst_gate #(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 5,
    parameter int LOG2_PRE = 6
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [2*DATA_W-1:0]   data_in_TDATA,
    input  logic                  data_in_TVALID,
    output logic                  data_in_TREADY,
    input  logic                  data_in_TLAST,
    output logic [2*DATA_W-1:0]   data_out_TDATA,
    output logic                  data_out_TVALID,
    input  logic                  data_out_TREADY,
    output logic                  data_out_TLAST,
    input  logic [31:0]           power_threshold_on_V,
    input  logic [31:0]           power_threshold_off_V,
    input  logic [15:0]           hang_len_V,
    input  logic [15:0]           max_len_V,
    output logic [31:0]           pkt_count_V,
    output logic                  gate_open
);
    localparam int PW    = 2 * DATA_W;
    localparam int SUM_W = PW + LOG2_WIN;
    localparam int WIN   = 1 << LOG2_WIN;
    localparam int PRE   = 1 << LOG2_PRE;
    localparam int EP_W  = LOG2_PRE + 17;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HANG} state_t;

    // Input TLAST carries no meaning for burst detection.
    logic unused_tlast;
    assign unused_tlast = data_in_TLAST;

    logic                  s1_valid;
    logic [PW-1:0]         s1_data, s1_pow, in_pow;
    logic signed [PW-1:0]  i_ext, q_ext, i_sq, q_sq;

    logic [PW-1:0]         win_ram [WIN];
    logic [LOG2_WIN-1:0]   win_ptr;
    logic [LOG2_WIN:0]     warm_cnt;
    logic [SUM_W-1:0]      win_sum, sum_next;
    logic [31:0]           avg;
    logic                  warm_full, avg_valid, above_on, below_off;

    state_t                state, fsm_next, state_next;
    logic [15:0]           hang_cnt, hang_next;

    logic [PW-1:0]         fifo_ram [PRE];
    logic [LOG2_PRE-1:0]   rd_ptr, wr_ptr;
    logic [LOG2_PRE:0]     fifo_cnt, fifo_cnt_next;
    logic [EP_W-1:0]       ep, ep_next;
    logic [15:0]           out_cnt, out_cnt_inc;
    logic                  fifo_full, fifo_empty, out_free, stall, push, pop, drop;
    logic                  open_evt, gated, last_end, last_max, out_last_next;

    // Power of the incoming sample; I^2 + Q^2 fits PW bits even at full scale.
    always_comb begin
        i_ext  = PW'($signed(data_in_TDATA[PW-1:DATA_W]));
        q_ext  = PW'($signed(data_in_TDATA[DATA_W-1:0]));
        i_sq   = i_ext * i_ext;
        q_sq   = q_ext * q_ext;
        in_pow = $unsigned(i_sq) + $unsigned(q_sq);
    end

    // Head-of-FIFO control; the whole front pipeline freezes while stalled.
    always_comb begin
        fifo_full  = (fifo_cnt == (LOG2_PRE+1)'(PRE));
        fifo_empty = (fifo_cnt == '0);
        out_free   = !data_out_TVALID || data_out_TREADY;
        stall      = fifo_full && (ep != '0) && !out_free;
        push       = s1_valid && !stall;
        pop        = (ep != '0) && !fifo_empty && out_free;
        drop       = push && (ep == '0) && fifo_full;
    end

    assign data_in_TREADY = !stall;
    assign gate_open      = (state != S_IDLE);

    // Stage 1: capture the accepted sample and its power.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_pow   <= '0;
        end else if (!stall) begin
            s1_valid <= data_in_TVALID;
            s1_data  <= data_in_TDATA;
            s1_pow   <= in_pow;
        end
    end

    // Window average including the current sample; the leaving value is zero until the window fills.
    always_comb begin
        warm_full = warm_cnt[LOG2_WIN];
        avg_valid = (warm_cnt >= (LOG2_WIN+1)'(WIN-1));
        sum_next  = win_sum + SUM_W'(s1_pow) - (warm_full ? SUM_W'(win_ram[win_ptr]) : '0);
        avg       = 32'(sum_next >> LOG2_WIN);
        above_on  = avg_valid && (avg >= power_threshold_on_V);
        below_off = (avg < power_threshold_off_V);
    end

    // Running sum, delay-line pointer and warm-up count.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            win_sum  <= '0;
            win_ptr  <= '0;
            warm_cnt <= '0;
        end else if (push) begin
            win_sum  <= sum_next;
            win_ptr  <= win_ptr + 1'b1;
            if (!warm_full) warm_cnt <= warm_cnt + 1'b1;
        end
    end

    // Delay line of power values.
    always_ff @(posedge ap_clk) begin
        if (push) win_ram[win_ptr] <= s1_pow;
    end

    // Gate FSM next state and hang counter, evaluated for the sample being pushed.
    always_comb begin
        fsm_next  = state;
        hang_next = hang_cnt;
        case (state)
            S_IDLE: begin
                if (above_on) fsm_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (below_off) begin
                    if (hang_len_V == 16'd0) begin
                        fsm_next = S_IDLE;
                    end else begin
                        fsm_next  = S_HANG;
                        hang_next = 16'd1;
                    end
                end
            end
            S_HANG: begin
                if (above_on) begin
                    fsm_next  = S_ACTIVE;
                    hang_next = 16'd0;
                end else if (below_off) begin
                    if (hang_cnt >= hang_len_V) begin
                        fsm_next  = S_IDLE;
                        hang_next = 16'd0;
                    end else if (hang_cnt != 16'hFFFF) begin
                        hang_next = hang_cnt + 16'd1;
                    end
                end
            end
            default: fsm_next = S_IDLE;
        endcase
        state_next = push ? fsm_next : state;
        open_evt   = push && (state == S_IDLE) && (fsm_next == S_ACTIVE);
        gated      = push && (fsm_next != S_IDLE);
    end

    // FSM state, hang counter and packet count registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            hang_cnt    <= '0;
            pkt_count_V <= '0;
        end else if (push) begin
            state    <= fsm_next;
            hang_cnt <= hang_next;
            if (open_evt) pkt_count_V <= pkt_count_V + 32'd1;
        end
    end

    // Owed-entry bookkeeping and TLAST decision for the sample leaving the FIFO.
    always_comb begin
        fifo_cnt_next = fifo_cnt;
        if (push && !(pop || drop)) fifo_cnt_next = fifo_cnt + 1'b1;
        else if (!push && (pop || drop)) fifo_cnt_next = fifo_cnt - 1'b1;
        ep_next = ep;
        if (open_evt && (ep == '0)) begin
            // Whole history, including the triggering sample, becomes owed.
            ep_next = EP_W'(fifo_cnt_next);
        end else begin
            if (pop)   ep_next = ep_next - EP_W'(1);
            if (gated) ep_next = ep_next + EP_W'(1);
        end
        out_cnt_inc   = out_cnt + 16'd1;
        last_end      = pop && (ep_next == '0) && (state_next == S_IDLE);
        last_max      = pop && (max_len_V != 16'd0) && (out_cnt_inc == max_len_V);
        out_last_next = last_end || last_max;
    end

    // FIFO pointers, occupancy, owed count and per-packet output count.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            ep       <= '0;
            out_cnt  <= '0;
        end else begin
            if (push)        wr_ptr <= wr_ptr + 1'b1;
            if (pop || drop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt_next;
            ep       <= ep_next;
            if (pop) out_cnt <= out_last_next ? 16'd0 : out_cnt_inc;
        end
    end

    // Pre-trigger history storage.
    always_ff @(posedge ap_clk) begin
        if (push) fifo_ram[wr_ptr] <= s1_data;
    end

    // Output register: loads the head when free, holds while stalled downstream.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            data_out_TVALID <= 1'b0;
            data_out_TDATA  <= '0;
            data_out_TLAST  <= 1'b0;
        end else if (pop) begin
            data_out_TVALID <= 1'b1;
            data_out_TDATA  <= fifo_ram[rd_ptr];
            data_out_TLAST  <= out_last_next;
        end else if (data_out_TREADY) begin
            data_out_TVALID <= 1'b0;
            data_out_TLAST  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lora_burst_gate.sv
// tb/tb_lora_burst_gate.sv - table-driven bench for lora_burst_gate with transaction-level model
module tb_lora_burst_gate;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [31:0] data_in_TDATA;
    logic        data_in_TVALID, data_in_TREADY, data_in_TLAST;
    logic [31:0] data_out_TDATA;
    logic        data_out_TVALID, data_out_TREADY, data_out_TLAST;
    logic [31:0] on_thr, off_thr, pkt_count;
    logic [15:0] hang_len, max_len;
    logic        gate_open;

    always #5 ap_clk = ~ap_clk;

    lora_burst_gate dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .data_in_TDATA(data_in_TDATA), .data_in_TVALID(data_in_TVALID),
        .data_in_TREADY(data_in_TREADY), .data_in_TLAST(data_in_TLAST),
        .data_out_TDATA(data_out_TDATA), .data_out_TVALID(data_out_TVALID),
        .data_out_TREADY(data_out_TREADY), .data_out_TLAST(data_out_TLAST),
        .power_threshold_on_V(on_thr), .power_threshold_off_V(off_thr),
        .hang_len_V(hang_len), .max_len_V(max_len),
        .pkt_count_V(pkt_count), .gate_open(gate_open)
    );

    typedef struct {
        int quiet; int loud_len; int loud_amp; int alt_blocks; int tail;
        int hang; int maxl; int slow_rdy; int abort_out;
        int exp_pkts; int exp_len; int exp_lasts;
    } scen_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] stim[$];
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    int          m_cnt;
    int          trig_idx;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input int i, input int a);
        int d, iv, qv;
        logic [31:0] w;
        d  = i % 8;
        iv = a + d;
        qv = a - d;
        if ((i & 8) != 0)  iv = -iv;
        if ((i & 16) != 0) qv = -qv;
        w = {iv[15:0], qv[15:0]};
        return w;
    endfunction

    task automatic build_stim(input scen_t s);
        int n;
        stim.delete();
        n = 0;
        for (int k = 0; k < s.quiet; k++) begin stim.push_back(mk(n, 10)); n++; end
        for (int k = 0; k < s.loud_len; k++) begin stim.push_back(mk(n, s.loud_amp)); n++; end
        for (int b = 0; b < s.alt_blocks; b++)
            for (int k = 0; k < 40; k++) begin stim.push_back(mk(n, (b % 2 == 0) ? 592 : 775)); n++; end
        for (int k = 0; k < s.tail; k++) begin stim.push_back(mk(n, 10)); n++; end
    endtask

    task automatic model_emit(input logic [31:0] d, input int maxl);
        bit l;
        m_cnt++;
        l = (maxl != 0) && (m_cnt == maxl);
        if (l) m_cnt = 0;
        exp_data.push_back(d);
        exp_last.push_back(l);
    endtask

    task automatic model_close();
        if (exp_last.size() > 0) exp_last[exp_last.size()-1] = 1'b1;
        m_cnt = 0;
    endtask

    // Sample-order model: history of up to 64 samples, window of 32, hysteresis FSM.
    task automatic run_model(input int hang, input int maxl);
        longint win[32];
        longint sum, p, avg;
        logic [31:0] hist[$];
        logic signed [15:0] iv, qv;
        int st, hc;
        exp_data.delete(); exp_last.delete();
        m_cnt = 0; trig_idx = -1; sum = 0; st = 0; hc = 0;
        for (int k = 0; k < 32; k++) win[k] = 0;
        for (int i = 0; i < stim.size(); i++) begin
            iv = stim[i][31:16];
            qv = stim[i][15:0];
            p = longint'(iv) * longint'(iv) + longint'(qv) * longint'(qv);
            sum = sum + p - win[i % 32];
            win[i % 32] = p;
            avg = sum / 32;
            if (st == 0) begin
                hist.push_back(stim[i]);
                if (hist.size() > 64) void'(hist.pop_front());
                if (i >= 31 && avg >= 1000000) begin
                    st = 1;
                    if (trig_idx < 0) trig_idx = i;
                    while (hist.size() > 0) model_emit(hist.pop_front(), maxl);
                end
            end else if (st == 1) begin
                if (avg < 500000 && hang == 0) begin
                    st = 0; model_close(); hist.push_back(stim[i]);
                end else if (avg < 500000) begin
                    st = 2; hc = 1; model_emit(stim[i], maxl);
                end else model_emit(stim[i], maxl);
            end else begin
                if (avg >= 1000000) begin
                    st = 1; hc = 0; model_emit(stim[i], maxl);
                end else if (avg < 500000 && hc >= hang) begin
                    st = 0; model_close(); hist.push_back(stim[i]);
                end else begin
                    if (avg < 500000) hc++;
                    model_emit(stim[i], maxl);
                end
            end
        end
    endtask

    task automatic run_scen(input string nm, input scen_t s);
        int idx, out_n, lasts, stalls, cyc, idle, first_cyc, trig_cyc, vcnt;
        bit acc, aborted;
        build_stim(s);
        run_model(s.hang, s.maxl);
        hang_len = 16'(s.hang);
        max_len  = 16'(s.maxl);
        ap_rst_n = 1'b0;
        data_in_TVALID = 1'b1;
        data_in_TDATA  = stim.size() > 0 ? stim[0] : 32'd0;
        data_out_TREADY = 1'b1;
        repeat (4) @(posedge ap_clk);
        @(negedge ap_clk);
        check({nm, ":rst_out_valid"}, data_out_TVALID, 0);
        check({nm, ":rst_out_last"}, data_out_TLAST, 0);
        check({nm, ":rst_out_data"}, data_out_TDATA, 0);
        check({nm, ":rst_pkt_count"}, pkt_count, 0);
        check({nm, ":rst_gate_open"}, gate_open, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        data_in_TVALID = stim.size() > 0;
        idx = 0; out_n = 0; lasts = 0; stalls = 0; cyc = 0; idle = 0;
        first_cyc = -1; trig_cyc = -1; aborted = 0;
        while (idle < 400) begin
            @(negedge ap_clk);
            if (cyc == 0) check({nm, ":tready_after_reset"}, data_in_TREADY, 1);
            acc = data_in_TVALID && data_in_TREADY;
            if (data_in_TVALID && !data_in_TREADY) stalls++;
            if (acc && idx == trig_idx) trig_cyc = cyc;
            if (data_out_TVALID && first_cyc < 0) first_cyc = cyc;
            if (data_out_TVALID && data_out_TREADY) begin
                if (out_n < exp_data.size()) begin
                    check($sformatf("%s:data[%0d]", nm, out_n), data_out_TDATA, exp_data[out_n]);
                    check($sformatf("%s:last[%0d]", nm, out_n), data_out_TLAST, exp_last[out_n]);
                end else begin
                    check({nm, ":output_overrun"}, out_n + 1, exp_data.size());
                end
                if (data_out_TLAST) lasts++;
                out_n++;
            end
            @(posedge ap_clk); #1;
            cyc++;
            if (acc) idx++;
            data_in_TVALID = idx < stim.size();
            if (idx < stim.size()) data_in_TDATA = stim[idx];
            data_out_TREADY = (s.slow_rdy != 0) ? (cyc % 3 == 0) : 1'b1;
            if (idx >= stim.size()) idle++;
            if (s.abort_out > 0 && out_n >= s.abort_out) begin aborted = 1; break; end
            if (cyc > 4 * stim.size() + 2000) begin
                check({nm, ":timeout"}, cyc, -1);
                break;
            end
        end
        if (aborted) begin
            ap_rst_n = 1'b0;
            data_in_TVALID = 1'b0;
            data_out_TREADY = 1'b1;
            @(posedge ap_clk);
            @(negedge ap_clk);
            check({nm, ":abort_valid"}, data_out_TVALID, 0);
            check({nm, ":abort_last"}, data_out_TLAST, 0);
            check({nm, ":abort_gate"}, gate_open, 0);
            check({nm, ":abort_pkt"}, pkt_count, 0);
            #1 ap_rst_n = 1'b1;
            vcnt = 0;
            for (int k = 0; k < 150; k++) begin
                @(negedge ap_clk);
                if (data_out_TVALID) vcnt++;
            end
            check({nm, ":abort_no_residue"}, vcnt, 0);
        end else begin
            check({nm, ":out_count"}, out_n, s.exp_len);
            check({nm, ":tlast_count"}, lasts, s.exp_lasts);
            check({nm, ":pkt_count"}, pkt_count, s.exp_pkts);
            check({nm, ":gate_closed"}, gate_open, 0);
            check({nm, ":stall_seen"}, stalls > 0, s.slow_rdy);
            if (s.exp_pkts > 0)
                check({nm, ":trigger_latency_le4"},
                      (first_cyc > trig_cyc) && (first_cyc - trig_cyc <= 4) && (trig_cyc >= 0), 1);
        end
    endtask

    initial begin
        scen_t tbl[6];
        string names[6];
        ap_rst_n = 1'b0;
        data_in_TVALID = 1'b0;
        data_in_TDATA = '0;
        data_in_TLAST = 1'b0;
        data_out_TREADY = 1'b1;
        on_thr = 32'd1000000;
        off_thr = 32'd500000;
        hang_len = 16'd8;
        max_len = 16'd0;
        //        quiet loud  amp  alt tail hang maxl slow abort pkts len lasts
        tbl[0] = '{1000,   0,    0, 0,   0,  8,   0,  0,   0,   0,   0, 0}; names[0] = "quiet";
        tbl[1] = '{ 200, 100, 1000, 0, 200,  8,   0,  0,   0,   1, 180, 1}; names[1] = "burst";
        tbl[2] = '{ 200, 100, 1000, 0, 200,  0,   0,  0,   0,   1, 172, 1}; names[2] = "hang0";
        tbl[3] = '{ 200,  40, 1000, 4, 200,  8,   0,  0,   0,   1, 274, 1}; names[3] = "hyst";
        tbl[4] = '{ 200,  50, 1000, 0, 200,  8,  50,  0,   0,   1, 130, 3}; names[4] = "maxlen";
        tbl[5] = '{ 200, 100, 1000, 0, 200,  8,   0,  1,   0,   1, 180, 1}; names[5] = "backpr";
        for (int t = 0; t < 6; t++) run_scen(names[t], tbl[t]);
        begin
            scen_t ab;
            ab = '{200, 100, 1000, 0, 200, 8, 0, 0, 20, 0, 0, 0};
            run_scen("abort", ab);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
